// File: rtl/izh_tdm_sched.sv
// izh_tdm_sched: time-division scheduler that shares one Izhikevich update
// core among NUM_NEURONS virtual neurons. A tick starts a sweep over all
// neurons in index order. For each neuron the sweep issues it to the core,
// waits for the result, writes it back and queues any spike on the spike port.
//
// Spike port handshake (spk_valid / spk_ready):
//   An event transfers on every rising edge where spk_valid and spk_ready are
//   both high. While spk_valid=1 and spk_ready=0, spk_id holds steady. A new
//   event may load on the same edge that the old one transfers. If no slot is
//   free, the sweep waits in COMMIT without writing back.
module izh_tdm_sched #(
  parameter int         NUM_NEURONS = 4,
  parameter int         IDX_W       = 2,
  parameter logic [7:0] V_RESET     = 8'hBF,
  parameter logic [7:0] U_INIT      = 8'h00,
  parameter int         TIMEOUT     = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             cur_we,
  input  logic [IDX_W-1:0] cur_addr,
  input  logic [7:0]       cur_data,
  output logic             core_start,
  output logic [7:0]       core_v_in,
  output logic [7:0]       core_u_in,
  output logic [7:0]       core_i_in,
  input  logic             core_done,
  input  logic [7:0]       core_v_out,
  input  logic [7:0]       core_u_out,
  input  logic             core_spike,
  output logic             spk_valid,
  input  logic             spk_ready,
  output logic [IDX_W-1:0] spk_id,
  output logic             busy,
  output logic             sweep_done,
  output logic [15:0]      step_count,
  output logic             overrun,
  output logic             timeout_err,
  input  logic [IDX_W-1:0] mon_addr,
  output logic [7:0]       mon_v
);

  // The wait counter holds 0..TIMEOUT-1. The last value is the cycle on which
  // the neuron is abandoned.
  localparam int               WC_W      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WC_W-1:0]  WAIT_LAST = WC_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_NEURONS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;

  // Per-neuron register files.
  logic [7:0] v_mem [NUM_NEURONS];
  logic [7:0] u_mem [NUM_NEURONS];
  logic [7:0] i_mem [NUM_NEURONS];

  // Holds the core result between WAIT and COMMIT. hold_abandon marks a
  // timed-out neuron, which keeps its old state and raises no spike.
  logic [7:0] hold_v, hold_u;
  logic       hold_spike, hold_abandon;

  // Strobes decoded by the next-state logic.
  logic issue_load;
  logic hold_load;
  logic timeout_hit;
  logic wb_en;
  logic spk_load;
  logic commit_go;
  logic slot_free;
  logic cur_ok;
  logic mon_ok;

  // Addresses above NUM_NEURONS-1 can exist only when NUM_NEURONS is not a
  // power of two. Writes to them are dropped and monitor reads return 0.
  if (NUM_NEURONS == (1 << IDX_W)) begin : g_full_range
    assign cur_ok = 1'b1;
    assign mon_ok = 1'b1;
  end else begin : g_part_range
    assign cur_ok = (cur_addr < IDX_W'(NUM_NEURONS));
    assign mon_ok = (mon_addr < IDX_W'(NUM_NEURONS));
  end

  assign busy       = (state_q != S_IDLE);
  assign core_start = (state_q == S_ISSUE);
  assign slot_free  = !spk_valid || spk_ready;
  assign mon_v      = mon_ok ? v_mem[mon_addr] : 8'h00;

  // Next-state decode: sweep sequencing, timeout and commit/backpressure decision.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wait_cnt_d  = wait_cnt_q;
    issue_load  = 1'b0;
    hold_load   = 1'b0;
    timeout_hit = 1'b0;
    wb_en       = 1'b0;
    spk_load    = 1'b0;
    commit_go   = 1'b0;
    sweep_done  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tick) begin
          idx_d      = '0;
          issue_load = 1'b1;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (core_done) begin
          hold_load = 1'b1;
          state_d   = S_COMMIT;
        end else if (wait_cnt_q == WAIT_LAST) begin
          timeout_hit = 1'b1;
          state_d     = S_COMMIT;
        end else begin
          wait_cnt_d = wait_cnt_q + WC_W'(1);
        end
      end
      S_COMMIT: begin
        if (hold_abandon) begin
          commit_go = 1'b1;
        end else if (!hold_spike) begin
          wb_en     = 1'b1;
          commit_go = 1'b1;
        end else if (slot_free) begin
          wb_en     = 1'b1;
          spk_load  = 1'b1;
          commit_go = 1'b1;
        end
        if (commit_go) begin
          if (idx_q == IDX_LAST) begin
            sweep_done = 1'b1;
            state_d    = S_IDLE;
          end else begin
            idx_d      = idx_q + IDX_W'(1);
            issue_load = 1'b1;
            state_d    = S_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers: FSM state, neuron index, wait counter, status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      wait_cnt_q  <= '0;
      step_count  <= 16'd0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wait_cnt_q <= wait_cnt_d;
      if (sweep_done) begin
        step_count <= step_count + 16'd1;
      end
      if (tick && busy) begin
        overrun <= 1'b1;
      end
      if (timeout_hit) begin
        timeout_err <= 1'b1;
      end
    end
  end

  // Register files: result writeback at COMMIT, host current writes every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < NUM_NEURONS; n++) begin
        v_mem[n] <= V_RESET;
        u_mem[n] <= U_INIT;
        i_mem[n] <= 8'h00;
      end
    end else begin
      if (wb_en) begin
        v_mem[idx_q] <= hold_v;
        u_mem[idx_q] <= hold_u;
      end
      if (cur_we && cur_ok) begin
        i_mem[cur_addr] <= cur_data;
      end
    end
  end

  // Issue operands are loaded on the edge that enters ISSUE. A current write
  // that lands on the same edge reaches the next sweep, not this one.
  always_ff @(posedge clk) begin
    if (reset) begin
      core_v_in <= 8'h00;
      core_u_in <= 8'h00;
      core_i_in <= 8'h00;
    end else if (issue_load) begin
      core_v_in <= v_mem[idx_d];
      core_u_in <= u_mem[idx_d];
      core_i_in <= i_mem[idx_d];
    end
  end

  // Capture the core response. A timeout marks the neuron as abandoned.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_v       <= 8'h00;
      hold_u       <= 8'h00;
      hold_spike   <= 1'b0;
      hold_abandon <= 1'b0;
    end else if (hold_load) begin
      hold_v       <= core_v_out;
      hold_u       <= core_u_out;
      hold_spike   <= core_spike;
      hold_abandon <= 1'b0;
    end else if (timeout_hit) begin
      hold_spike   <= 1'b0;
      hold_abandon <= 1'b1;
    end
  end

  // Spike output slot. A new load takes priority over the clear on transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      spk_valid <= 1'b0;
      spk_id    <= '0;
    end else if (spk_load) begin
      spk_valid <= 1'b1;
      spk_id    <= idx_q;
    end else if (spk_valid && spk_ready) begin
      spk_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_izh_tdm_sched.sv
// Bench for izh_tdm_sched: a behavioural core responder, a neuron-state model,
// a spike event queue, directed scenarios and randomized sweeps.
module tb_izh_tdm_sched;

  localparam int NN    = 4;
  localparam int IDX_W = 2;

  // Clock and reset.
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, tick, cur_we;
  logic [IDX_W-1:0] cur_addr, mon_addr, spk_id;
  logic [7:0]       cur_data, core_v_in, core_u_in, core_i_in;
  logic [7:0]       core_v_out, core_u_out, mon_v;
  logic             core_start, core_done, core_spike;
  logic             spk_valid, spk_ready, busy, sweep_done, overrun, timeout_err;
  logic [15:0]      step_count;

  izh_tdm_sched #(.NUM_NEURONS(NN), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .tick(tick),
    .cur_we(cur_we), .cur_addr(cur_addr), .cur_data(cur_data),
    .core_start(core_start), .core_v_in(core_v_in), .core_u_in(core_u_in),
    .core_i_in(core_i_in), .core_done(core_done), .core_v_out(core_v_out),
    .core_u_out(core_u_out), .core_spike(core_spike),
    .spk_valid(spk_valid), .spk_ready(spk_ready), .spk_id(spk_id),
    .busy(busy), .sweep_done(sweep_done), .step_count(step_count),
    .overrun(overrun), .timeout_err(timeout_err),
    .mon_addr(mon_addr), .mon_v(mon_v)
  );

  // Result accounting.
  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  // Model state: neuron v/u, currents, sweep count, expected spike events.
  logic [7:0]       v_m [NN];
  logic [7:0]       u_m [NN];
  logic [7:0]       cur_m [NN];
  logic [7:0]       cur_prev [NN];
  logic [IDX_W-1:0] exp_q [$];
  int               steps_m = 0;
  int               done_cnt = 0;
  int               issue_k = 0;
  int               start_total = 0;
  logic [7:0]       last_i [NN];

  // Scenario knobs for the responder.
  logic [NN-1:0] spike_mask = '0;
  logic [NN-1:0] silent_mask = '0;
  bit            rand_mode = 1'b0;

  // Per-cycle records of one sweep, indexed by cycle number after the tick.
  logic rec_busy [512];
  logic rec_valid [512];
  logic [IDX_W-1:0] rec_id [512];
  logic rec_terr [512];
  logic rec_ovr [512];
  logic rec_start [512];

  // Current model: an issue sees the value held before the edge that enters ISSUE.
  always @(posedge clk) begin
    for (int n = 0; n < NN; n++) cur_prev[n] <= cur_m[n];
    if (reset) begin
      for (int n = 0; n < NN; n++) cur_m[n] <= 8'h00;
    end else if (cur_we) begin
      cur_m[cur_addr] <= cur_data;
    end
  end

  // Core responder and issue-stream checker.
  initial begin
    int k;
    int lat;
    logic [7:0] rv, ru;
    logic sp;
    core_done = 1'b0; core_v_out = 8'h00; core_u_out = 8'h00; core_spike = 1'b0;
    forever begin
      @(negedge clk);
      if (core_start && !reset) begin
        k = issue_k;
        issue_k = (issue_k + 1) % NN;
        start_total++;
        chk($sformatf("core_v_in[%0d]", k), core_v_in, v_m[k]);
        chk($sformatf("core_u_in[%0d]", k), core_u_in, u_m[k]);
        chk($sformatf("core_i_in[%0d]", k), core_i_in, cur_prev[k]);
        last_i[k] = core_i_in;
        if (!silent_mask[k]) begin
          if (rand_mode) begin
            lat = $urandom_range(1, 4);
            rv = 8'($urandom);
            ru = 8'($urandom);
            sp = ($urandom_range(0, 2) == 0);
          end else begin
            lat = 1;
            rv = core_v_in + 8'd1;
            ru = core_u_in;
            sp = spike_mask[k];
          end
          repeat (lat) @(posedge clk);
          #1;
          core_done = 1'b1; core_v_out = rv; core_u_out = ru; core_spike = sp;
          v_m[k] = rv;
          u_m[k] = ru;
          if (sp) exp_q.push_back(IDX_W'(k));
          @(posedge clk);
          #1;
          core_done = 1'b0; core_spike = 1'b0;
        end
      end
    end
  end

  // Spike scoreboard: compares every transfer with the queue and checks that held events are stable.
  initial begin
    logic prev_hold;
    logic [IDX_W-1:0] prev_id;
    prev_hold = 1'b0;
    prev_id = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          chk("spk_hold_valid", spk_valid, 1);
          chk("spk_hold_id", spk_id, prev_id);
        end
        if (spk_valid && spk_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spk_unexpected id=%0d expected no event", spk_id);
          end else begin
            chk("spk_id", spk_id, exp_q.pop_front());
          end
        end
        prev_hold = spk_valid && !spk_ready;
        prev_id = spk_id;
      end
    end
  end

  // Sweep-done pulse counter.
  initial forever begin
    @(negedge clk);
    if (sweep_done && !reset) done_cnt++;
  end

  // Watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Driver tasks.
  task automatic write_cur(input int a, input logic [7:0] d);
    @(posedge clk); #1;
    cur_we = 1'b1; cur_addr = IDX_W'(a); cur_data = d;
    @(posedge clk); #1;
    cur_we = 1'b0;
  endtask

  task automatic check_mon();
    for (int a = 0; a < NN; a++) begin
      mon_addr = IDX_W'(a);
      #1;
      chk($sformatf("mon_v[%0d]", a), mon_v, v_m[a]);
    end
  endtask

  task automatic check_mon_lit(input logic [7:0] e0, e1, e2, e3);
    logic [7:0] e [NN];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int a = 0; a < NN; a++) begin
      mon_addr = IDX_W'(a);
      #1;
      chk($sformatf("mon_v_lit[%0d]", a), mon_v, e[a]);
    end
  endtask

  task automatic drain();
    @(posedge clk); #1;
    spk_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("spk_queue_drained", exp_q.size(), 0);
    chk("spk_valid_drained", spk_valid, 0);
  endtask

  // One sweep: tick on cycle 0, then per-cycle extra tick, current write and ready control.
  task automatic run_sweep(input int tick2_at, input int wr_at, input int wr_addr,
                           input logic [7:0] wr_data, input int ready_at, output int ncyc);
    bit got;
    got = 1'b0;
    ncyc = 0;
    @(posedge clk); #1;
    tick = 1'b1;
    for (int n = 1; n < 400; n++) begin
      @(posedge clk); #1;
      tick = (n == tick2_at);
      cur_we = 1'b0;
      if (n == wr_at) begin
        cur_we = 1'b1; cur_addr = IDX_W'(wr_addr); cur_data = wr_data;
      end else if (rand_mode && $urandom_range(0, 3) == 0) begin
        cur_we = 1'b1; cur_addr = IDX_W'($urandom_range(0, NN - 1)); cur_data = 8'($urandom);
      end
      if (rand_mode) spk_ready = 1'($urandom_range(0, 1));
      else if (ready_at >= 0) spk_ready = (n == ready_at);
      else spk_ready = 1'b1;
      @(negedge clk);
      rec_busy[n] = busy; rec_valid[n] = spk_valid; rec_id[n] = spk_id;
      rec_terr[n] = timeout_err; rec_ovr[n] = overrun; rec_start[n] = core_start;
      if (sweep_done) begin
        got = 1'b1;
        ncyc = n;
        break;
      end
    end
    chk("sweep_done_seen", got, 1);
    steps_m++;
    @(posedge clk); #1;
    tick = 1'b0; cur_we = 1'b0;
    @(negedge clk);
    chk("step_count", step_count, steps_m);
    chk("busy_after_sweep", busy, 0);
  endtask

  // Main sequence.
  initial begin
    int n;
    int s0;
    reset = 1'b1; tick = 1'b0; cur_we = 1'b0; cur_addr = '0; cur_data = 8'h00;
    spk_ready = 1'b1; mon_addr = '0;
    for (int a = 0; a < NN; a++) begin
      v_m[a] = 8'hBF; u_m[a] = 8'h00; last_i[a] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    // Reset state.
    check_mon_lit(8'hBF, 8'hBF, 8'hBF, 8'hBF);
    chk("rst_step_count", step_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_spk_valid", spk_valid, 0);
    chk("rst_spk_id", spk_id, 0);
    chk("rst_sweep_done", sweep_done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_core_in", {core_v_in, core_u_in, core_i_in}, 0);

    // Basic sweep with known currents.
    write_cur(0, 8'h10); write_cur(1, 8'h20); write_cur(2, 8'h30); write_cur(3, 8'h40);
    s0 = start_total;
    run_sweep(0, 0, 0, 8'h00, -1, n);
    chk("sweep1_len", n, 12);
    chk("sweep1_starts", start_total - s0, 4);
    chk("sweep1_i0", last_i[0], 8'h10);
    chk("sweep1_i1", last_i[1], 8'h20);
    chk("sweep1_i2", last_i[2], 8'h30);
    chk("sweep1_i3", last_i[3], 8'h40);
    check_mon_lit(8'hC0, 8'hC0, 8'hC0, 8'hC0);
    chk("sweep1_step", step_count, 1);

    // Spike backpressure: neurons 1 and 2 fire, consumer stalls until cycle 15.
    spike_mask = 4'b0110;
    spk_ready = 1'b0;
    run_sweep(0, 0, 0, 8'h00, 15, n);
    spike_mask = '0;
    chk("bp_id_held", rec_id[14], 1);
    chk("bp_valid_held", rec_valid[14], 1);
    chk("bp_busy_stalled", rec_busy[14], 1);
    chk("bp_id_next", rec_id[16], 2);
    chk("bp_len", n, 18);
    drain();
    check_mon_lit(8'hC1, 8'hC1, 8'hC1, 8'hC1);

    // Core never answers neuron 2.
    silent_mask = 4'b0100;
    run_sweep(0, 0, 0, 8'h00, -1, n);
    silent_mask = '0;
    chk("to_err_before", rec_terr[22], 0);
    chk("to_err_after", rec_terr[23], 1);
    chk("to_len", n, 26);
    chk("to_err_sticky", timeout_err, 1);
    check_mon_lit(8'hC2, 8'hC2, 8'hC1, 8'hC2);

    // Tick while busy sets overrun and does not start another sweep.
    run_sweep(5, 0, 0, 8'h00, -1, n);
    chk("ovr_before", rec_ovr[5], 0);
    chk("ovr_after", rec_ovr[6], 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("ovr_no_extra_busy", busy, 0);
    chk("ovr_step", step_count, 4);

    // Tick during the sweep_done cycle and a current write during neuron 3's ISSUE.
    run_sweep(12, 10, 3, 8'h77, -1, n);
    chk("late_len", n, 12);
    chk("late_issue_cycle", rec_start[10], 1);
    chk("late_i3_old", last_i[3], 8'h40);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("late_tick_ignored", busy, 0);
    chk("late_step", step_count, 5);
    run_sweep(0, 0, 0, 8'h00, -1, n);
    chk("next_i3_new", last_i[3], 8'h77);
    check_mon();

    // core_done outside WAIT is ignored.
    @(posedge clk); #1;
    core_done = 1'b1; core_v_out = 8'h5A; core_u_out = 8'hA5; core_spike = 1'b1;
    @(posedge clk); #1;
    core_done = 1'b0; core_spike = 1'b0;
    @(negedge clk);
    chk("stray_done_busy", busy, 0);
    chk("stray_done_spk", spk_valid, 0);
    check_mon();

    // Randomized sweeps.
    rand_mode = 1'b1;
    for (int s = 0; s < 20; s++) begin
      run_sweep(0, 0, 0, 8'h00, -1, n);
      check_mon();
    end
    rand_mode = 1'b0;
    drain();
    chk("sweep_done_pulses", done_cnt, steps_m);

    // Reset asserted during neuron 2's WAIT, with a spike pending.
    spike_mask = 4'b0001;
    spk_ready = 1'b0;
    @(posedge clk); #1;
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    repeat (7) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    spike_mask = '0;
    check_mon_lit(8'hBF, 8'hBF, 8'hBF, 8'hBF);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_spk_valid", spk_valid, 0);
    chk("mid_rst_overrun", overrun, 0);
    chk("mid_rst_timeout_err", timeout_err, 0);
    chk("mid_rst_step", step_count, 0);
    exp_q.delete();
    for (int a = 0; a < NN; a++) begin
      v_m[a] = 8'hBF; u_m[a] = 8'h00;
    end
    steps_m = 0;
    issue_k = 0;
    done_cnt = 0;
    spk_ready = 1'b1;

    // Clean sweep after reset.
    run_sweep(0, 0, 0, 8'h00, -1, n);
    chk("post_rst_len", n, 12);
    chk("post_rst_i0", last_i[0], 8'h00);
    chk("post_rst_i3", last_i[3], 8'h00);
    check_mon_lit(8'hC0, 8'hC0, 8'hC0, 8'hC0);
    chk("post_rst_step", step_count, 1);
    chk("post_rst_pulses", done_cnt, steps_m);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/izh_tdm_sched.md
Name: izh_tdm_sched

Overview:
Time-division scheduler that shares one Izhikevich update core among NUM_NEURONS virtual neurons.
- Holds per-neuron membrane state (v, u) and input current in internal register files.
- On each timestep tick, sweeps all neurons in index order: issues each to the core, waits for the result, writes it back and emits spike events through a valid/ready port.
- Sits between the tt_um top level (host current writes, spike and monitor outputs) and the izh core.

Parameters:
- NUM_NEURONS, 4: virtual neurons; 2..16.
- IDX_W, 2: index width; must equal clog2(NUM_NEURONS).
- V_RESET, 8'hBF: reset value of every v entry (-65, signed 8-bit).
- U_INIT, 8'h00: reset value of every u entry.
- TIMEOUT, 15: maximum WAIT cycles before the neuron is abandoned.

Ports:
- clk, in, 1: clock; all logic on the rising edge.
- reset, in, 1: synchronous, active-high reset.
- tick, in, 1: timestep strobe; starts a sweep when IDLE.
- cur_we, in, 1: current write enable.
- cur_addr, in, IDX_W: neuron index for the current write.
- cur_data, in, 8: unsigned input current.
- core_start, out, 1: one-cycle issue pulse to the core.
- core_v_in, out, 8: signed v of the issued neuron.
- core_u_in, out, 8: signed u of the issued neuron.
- core_i_in, out, 8: current of the issued neuron.
- core_done, in, 1: result-valid pulse from the core.
- core_v_out, in, 8: updated v.
- core_u_out, in, 8: updated u.
- core_spike, in, 1: neuron fired this step.
- spk_valid, out, 1: spike event pending.
- spk_ready, in, 1: consumer accepts the event.
- spk_id, out, IDX_W: index of the neuron that fired.
- busy, out, 1: high whenever the state is not IDLE.
- sweep_done, out, 1: one-cycle pulse when the last neuron commits.
- step_count, out, 16: completed sweeps; wraps 0xFFFF -> 0.
- overrun, out, 1: sticky; a tick arrived while busy.
- timeout_err, out, 1: sticky; a core response timed out.
- mon_addr, in, IDX_W: monitor select.
- mon_v, out, 8: combinational v_mem[mon_addr].

Behaviour:
Reset (synchronous, high): values that hold while reset is high and on the first cycle after it.
- All v = V_RESET, all u = U_INIT, all currents = 0.
- State IDLE, idx = 0, step_count = 0.
- spk_valid, spk_id, busy, sweep_done, overrun, timeout_err, core_start all 0.
- core_v_in, core_u_in and core_i_in are registered and reset to 0.
- Reset mid-sweep aborts the sweep; partially updated neurons revert to reset values.

FSM: IDLE -> ISSUE -> WAIT -> COMMIT -> (ISSUE | IDLE).
- IDLE: tick=1 sets idx=0 and moves to ISSUE next cycle.
- ISSUE (exactly 1 cycle): core_start=1. core_*_in are driven from the v/u/current entries of idx as read at the ISSUE edge. Next state WAIT.
- WAIT, core_done=1: capture core_v_out, core_u_out and core_spike into holding registers, then go to COMMIT.
- WAIT timeout: on the TIMEOUT-th consecutive cycle without core_done, set timeout_err. That neuron keeps its old v/u and emits no spike. Proceed as a COMMIT with no writeback.
- core_done outside WAIT is ignored.
- COMMIT with no held spike: write v/u to idx.
- COMMIT with a held spike: the spike slot counts as free if spk_valid=0 or spk_ready=1 this cycle. If free, write v/u and load spk_valid=1, spk_id=idx. If not free, stay in COMMIT with no writeback; backpressure stalls the sweep.
- Leaving COMMIT: if idx == NUM_NEURONS-1, pulse sweep_done, increment step_count and go to IDLE. Otherwise idx+1 and go to ISSUE.
- Minimum sweep length, with the core answering 1 cycle after start: 3*NUM_NEURONS cycles.

Spike port:
- spk_valid clears on a cycle where spk_valid & spk_ready.
- A simultaneous accept and new load results in spk_valid=1 with the new id.
- spk_id is stable while spk_valid=1 and spk_ready=0.

Tick handling:
- tick while busy is ignored and sets overrun.
- tick on the same cycle sweep_done is asserted is also ignored (the state is still COMMIT).
- overrun and timeout_err clear only on reset.

Current writes:
- Accepted every cycle, including mid-sweep; the write lands at the clock edge.
- A write to idx on the same cycle as that neuron's ISSUE edge: the issue uses the old value, and the new value is stored for the next step.

Arithmetic: no arithmetic on v/u; the scheduler passes values through unmodified.

Test Plan:
- Reset, then set mon_addr=0..3 -> mon_v=0xBF for every address; step_count=0; busy=0; spk_valid=0.
- Bench core returns v_in+1, u_in, spike=0 with a 1-cycle latency; pulse tick once -> core_start pulses 4 times, core_i_in in issue order 0x10/0x20/0x30/0x40 after matching writes; sweep_done once after 12 cycles; each mon_v=0xC0; step_count=1.
- Core asserts spike for neurons 1 and 2; spk_ready held 0 -> spk_id=1; sweep stalls in COMMIT for neuron 2 with busy=1. Raise spk_ready for 1 cycle -> spk_id=2 on the next cycle, then the sweep finishes.
- Core never answers neuron 2 -> after 15 WAIT cycles timeout_err=1; neuron 2 v unchanged; neurons 0, 1 and 3 updated; sweep_done still fires.
- tick pulsed 5 cycles into a sweep -> overrun=1 and no extra sweep (step_count +1 only). cur_we to neuron 3 during neuron 3's ISSUE cycle -> core_i_in carries the old current; the next sweep carries the new one.
- Assert reset mid-WAIT -> next cycle: all mon_v=0xBF, busy=0, spk_valid=0, overrun=0, timeout_err=0.
